// File: rtl/fpcvt_pkg.sv
// Shared definitions for the 8-bit float sample path: field widths, the
// packed float sample type, and the accumulator FSM state encoding.
package fpcvt_pkg;

  localparam int FP_E_W     = 3;
  localparam int FP_F_W     = 5;
  localparam int LIN_W      = 13;
  localparam int FP_MAG_MAX = 3968;

  typedef struct packed {
    logic              s;
    logic [FP_E_W-1:0] e;
    logic [FP_F_W-1:0] f;
  } fp8_t;

  typedef enum logic {
    ST_ACCUM,
    ST_DONE
  } state_t;

endpackage

// File: rtl/fp_sample_accum_if.sv
// Sample-in / frame-total-out handshake bundle for fp_sample_accum.
// master = producer/consumer side, slave = the accumulator.
interface fp_sample_accum_if
  import fpcvt_pkg::*;
#(
  parameter int ACC_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic              in_s;
  logic [FP_E_W-1:0] in_e;
  logic [FP_F_W-1:0] in_f;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_ovf;

  modport master (
    output in_valid, in_s, in_e, in_f, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, in_s, in_e, in_f, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/fp8_decode.sv
// Combinational decode of an 8-bit float {s,e,f} to a signed linear value
// (f << e, negated when s is set). Negative zero decodes to 0.
module fp8_decode
  import fpcvt_pkg::*;
(
  input  fp8_t                    fp,
  output logic signed [LIN_W-1:0] val
);
  logic [LIN_W-2:0] mag;

  always_comb begin
    mag = {{(LIN_W-1-FP_F_W){1'b0}}, fp.f} << fp.e;
    val = fp.s ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  end
endmodule

// File: rtl/fp_sample_accum.sv
// Frame accumulator: decodes float samples and sums NUM_SAMPLES of them into
// a held frame total. Define FP_ACCUM_SATURATE_EN to clamp instead of wrap.
//
//   state    | meaning
//   ST_ACCUM | accepting samples, building the running sum
//   ST_DONE  | frame total presented, waiting for out_ready
module fp_sample_accum
  import fpcvt_pkg::*;
#(
  parameter int NUM_SAMPLES = 8,
  parameter int ACC_W       = 16
) (
  input logic               clk,
  input logic               rst_n,
  input logic               clr,
  fp_sample_accum_if.slave  bus
);
  localparam int CNT_W = $clog2(NUM_SAMPLES + 1);

  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         count;
  logic signed [ACC_W-1:0]  acc, acc_nxt, sum_q, val_ext, sum_raw;
  logic signed [LIN_W-1:0]  lin_val;
  logic                     ovf_q, add_ovf, accept, last;
  logic                     in_ready_c, out_valid_c;
  fp8_t                     sample;

  assign sample = {bus.in_s, bus.in_e, bus.in_f};

  fp8_decode u_decode (
    .fp  (sample),
    .val (lin_val)
  );

  // Overflow is only possible when both operands share a sign and the result flips it.
  always_comb begin
    val_ext = ACC_W'(lin_val);
    sum_raw = acc + val_ext;
    add_ovf = (acc[ACC_W-1] == val_ext[ACC_W-1]) && (sum_raw[ACC_W-1] != acc[ACC_W-1]);
`ifdef FP_ACCUM_SATURATE_EN
    if (add_ovf)
      acc_nxt = acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      acc_nxt = sum_raw;
`else
    acc_nxt = sum_raw;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_ACCUM;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACCUM: if (accept && last) state_nxt = ST_DONE;
      ST_DONE:  if (clr || bus.out_ready) state_nxt = ST_ACCUM;
      default:  state_nxt = ST_ACCUM;
    endcase
  end

  always_comb begin
    in_ready_c  = (state == ST_ACCUM) && !clr;
    out_valid_c = (state == ST_DONE);
    accept      = in_ready_c && bus.in_valid;
    last        = (count == CNT_W'(NUM_SAMPLES - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      acc   <= '0;
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else if (clr || (out_valid_c && bus.out_ready)) begin
      count <= '0;
      acc   <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      count <= count + CNT_W'(1);
      acc   <= acc_nxt;
      ovf_q <= ovf_q | add_ovf;
      if (last) sum_q <= acc_nxt;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_sum   = sum_q;
  assign bus.out_ovf   = ovf_q;
endmodule
